// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core sharing a single req/ready memory port.
// Each instruction runs FETCH/DECODE/EXEC[/MEM][/WB]; illegal or misaligned accesses halt the core.
module multicycle_mips_core #(
   parameter int unsigned        ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [31:0]       retired_count,
   input  logic [4:0]        dbg_reg_sel,
   output logic [31:0]       dbg_reg_data
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_JR  = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_target;
   logic [ADDR_W-1:0]  r_maddr;
   logic [31:0]        r_ir;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_alu;
   logic [4:0]         r_dest;
   logic               r_halted;
   logic [31:0]        r_retired;
   logic [31:0]        r_regs [0:31];

   logic [5:0]         w_op;
   logic [5:0]         w_funct;
   logic [31:0]        w_simm;
   logic               w_legal;
   logic [31:0]        w_alu;
   logic [ADDR_W-1:0]  w_maddr;
   logic [ADDR_W-1:0]  w_jaddr;
   logic [ADDR_W-1:0]  w_addr;

   always_comb begin
      w_op    = r_ir[31:26];
      w_funct = r_ir[5:0];
      w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
      w_maddr = ADDR_W'(r_a + w_simm);
      // Upper PC nibble only survives when ADDR_W exceeds 28 bits.
      w_jaddr = ADDR_W'({4'(32'(r_pc) >> 28), r_ir[25:0], 2'b00});

      w_legal = 1'b0;
      case (w_op)
         OP_RTYPE: w_legal = (w_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR});
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: w_legal = 1'b1;
         default:  w_legal = 1'b0;
      endcase

      case (w_funct)
         F_SUB:   w_alu = r_a - r_b;
         F_AND:   w_alu = r_a & r_b;
         F_OR:    w_alu = r_a | r_b;
         F_SLT:   w_alu = 32'($signed(r_a) < $signed(r_b));
         default: w_alu = r_a + r_b;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_target  <= '0;
         r_maddr   <= '0;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu     <= '0;
         r_dest    <= '0;
         r_halted  <= 1'b0;
         r_retired <= '0;
         r_regs    <= '{default: '0};
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir    <= mem_rdata;
                  r_pc    <= r_pc + ADDR_W'(4);
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a      <= r_regs[r_ir[25:21]];
               r_b      <= r_regs[r_ir[20:16]];
               r_target <= r_pc + ADDR_W'(w_simm << 2);
               r_dest   <= (w_op == OP_RTYPE) ? r_ir[15:11] : r_ir[20:16];
               if (w_legal) begin
                  r_state <= S_EXEC;
               end else begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end
            end
            S_EXEC: begin
               case (w_op)
                  OP_RTYPE: begin
                     if (w_funct == F_JR) begin
                        r_pc      <= ADDR_W'(r_a);
                        r_retired <= r_retired + 32'd1;
                        r_state   <= S_FETCH;
                     end else begin
                        r_alu   <= w_alu;
                        r_state <= S_WB;
                     end
                  end
                  OP_ADDI: begin
                     r_alu   <= r_a + w_simm;
                     r_state <= S_WB;
                  end
                  OP_LW, OP_SW: begin
                     if (w_maddr[1:0] != 2'b00) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                     end else begin
                        r_maddr <= w_maddr;
                        r_state <= S_MEM;
                     end
                  end
                  OP_BEQ, OP_BNE: begin
                     if ((r_a == r_b) == (w_op == OP_BEQ)) r_pc <= r_target;
                     r_retired <= r_retired + 32'd1;
                     r_state   <= S_FETCH;
                  end
                  OP_J, OP_JAL: begin
                     // r_pc already holds the link value (old PC + 4).
                     if (w_op == OP_JAL) r_regs[31] <= 32'(r_pc);
                     r_pc      <= w_jaddr;
                     r_retired <= r_retired + 32'd1;
                     r_state   <= S_FETCH;
                  end
                  default: begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (w_op == OP_SW) begin
                     r_retired <= r_retired + 32'd1;
                     r_state   <= S_FETCH;
                  end else begin
                     r_alu   <= mem_rdata;
                     r_state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (r_dest != 5'd0) r_regs[r_dest] <= r_alu;
               r_retired <= r_retired + 32'd1;
               r_state   <= S_FETCH;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

   always_comb begin
      w_addr        = (r_state == S_MEM) ? r_maddr : r_pc;
      mem_req       = rst_n && ((r_state == S_FETCH) || (r_state == S_MEM));
      mem_we        = rst_n && (r_state == S_MEM) && (w_op == OP_SW);
      mem_addr      = w_addr & ~ADDR_W'(3);
      mem_wdata     = r_b;
      halted        = r_halted;
      retired_count = r_retired;
      dbg_reg_data  = r_regs[dbg_reg_sel];
   end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed self-checking bench for multicycle_mips_core (ADDR_W=8, RESET_PC=0x40).
module tb_multicycle_mips_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready = 1'b1;
   logic        halted;
   logic [31:0] retired_count;
   logic [4:0]  dbg_reg_sel = 5'd0;
   logic [31:0] dbg_reg_data;

   logic [31:0] mem [0:63];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;
   logic [7:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   always #5 clk = ~clk;

   multicycle_mips_core #(.ADDR_W(8), .RESET_PC(8'h40)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .halted(halted), .retired_count(retired_count),
      .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data)
   );

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_req && mem_we && mem_ready) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      dbg_reg_sel = r;
      #1;
      chk(tag, dbg_reg_data, exp);
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'hFC000000;
   endtask

   task automatic restart();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int w0;
      int reqs;

      // Reset and arithmetic/store program
      fill_mem();
      mem[16] = 32'h20010005;   // addi $1,$0,5
      mem[17] = 32'h20020007;   // addi $2,$0,7
      mem[18] = 32'h00221820;   // add  $3,$1,$2
      mem[19] = 32'hAC030010;   // sw   $3,0x10($0)
      w0 = wr_cnt;
      rst_n = 1'b0;
      tick(3);
      chk("reset_req", 32'(mem_req), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_retired", retired_count, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_req", 32'(mem_req), 32'd1);
      chk("first_addr", 32'(mem_addr), 32'h40);
      tick(4);
      chk("addi_retire_cnt", retired_count, 32'd1);
      tick(11);
      chk("sw_req", 32'(mem_req), 32'd1);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_addr", 32'(mem_addr), 32'h10);
      chk("sw_wdata", mem_wdata, 32'h0000000C);
      tick(1);
      chk("prog1_retired", retired_count, 32'd4);
      chk("sw_write_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("sw_write_addr", 32'(wr_addr), 32'h10);
      chk("sw_write_data", wr_data, 32'h0000000C);
      chk_reg("reg3", 5'd3, 32'd12);
      chk_reg("reg1", 5'd1, 32'd5);

      // Load with wait states in FETCH and MEM
      fill_mem();
      mem[2]  = 32'hDEADBEEF;
      mem[16] = 32'h8C040008;   // lw $4,0x08($0)
      mem_ready = 1'b0;
      restart();
      chk_reg("reg3_cleared", 5'd3, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("lw_fetch_req", 32'(mem_req), 32'd1);
         chk("lw_fetch_addr", 32'(mem_addr), 32'h40);
         tick(1);
      end
      mem_ready = 1'b1;
      chk("lw_fetch_addr_rdy", 32'(mem_addr), 32'h40);
      tick(1);
      mem_ready = 1'b0;
      chk("lw_decode_noreq", 32'(mem_req), 32'd0);
      tick(2);
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_req", 32'(mem_req), 32'd1);
         chk("lw_mem_we", 32'(mem_we), 32'd0);
         chk("lw_mem_addr", 32'(mem_addr), 32'h08);
         tick(1);
      end
      mem_ready = 1'b1;
      chk("lw_mem_addr_rdy", 32'(mem_addr), 32'h08);
      tick(1);
      chk("lw_not_yet_retired", retired_count, 32'd0);
      tick(1);
      chk("lw_retired", retired_count, 32'd1);
      chk_reg("reg4", 5'd4, 32'hDEADBEEF);

      // Control flow: beq fall-through, j, jal, jr, bne self-loop
      fill_mem();
      mem[16] = 32'h20010001;   // addi $1,$0,1
      mem[17] = 32'h20020002;   // addi $2,$0,2
      mem[18] = 32'h10220005;   // beq  $1,$2,+5
      mem[19] = 32'h08000002;   // j    0x08
      mem[2]  = 32'h0C000008;   // jal  0x20
      mem[8]  = 32'h03E00008;   // jr   $31
      mem[3]  = 32'h1422FFFF;   // bne  $1,$2,-1
      restart();
      tick(11);
      chk("beq_fallthru_addr", 32'(mem_addr), 32'h4C);
      chk("beq_retired", retired_count, 32'd3);
      tick(3);
      chk("j_addr", 32'(mem_addr), 32'h08);
      tick(3);
      chk("jal_addr", 32'(mem_addr), 32'h20);
      chk_reg("jal_link", 5'd31, 32'h0C);
      tick(3);
      chk("jr_addr", 32'(mem_addr), 32'h0C);
      chk("jr_retired", retired_count, 32'd6);
      tick(3);
      chk("bne_loop1", 32'(mem_addr), 32'h0C);
      tick(3);
      chk("bne_loop2", 32'(mem_addr), 32'h0C);
      chk("bne_retired", retired_count, 32'd8);

      // Illegal opcode halts
      fill_mem();
      mem[16] = 32'h20050003;   // addi $5,$0,3
      mem[17] = 32'hFC000000;   // illegal
      restart();
      tick(5);
      chk("illegal_not_halted_yet", 32'(halted), 32'd0);
      tick(1);
      chk("illegal_halted", 32'(halted), 32'd1);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req) reqs++;
         tick(1);
      end
      chk("illegal_req_cycles", 32'(reqs), 32'd0);
      chk("illegal_retired", retired_count, 32'd1);
      chk_reg("reg5", 5'd5, 32'd3);

      // $0 stays zero; misaligned lw halts without a request
      fill_mem();
      mem[16] = 32'h20000009;   // addi $0,$0,9
      mem[17] = 32'h20060011;   // addi $6,$0,0x11
      mem[18] = 32'h8CC70000;   // lw   $7,0($6)
      restart();
      chk("halt_cleared_by_reset", 32'(halted), 32'd0);
      tick(8);
      chk_reg("reg0_zero", 5'd0, 32'd0);
      chk_reg("reg6", 5'd6, 32'h11);
      chk("mis_retired_pre", retired_count, 32'd2);
      tick(2);
      chk("mis_not_halted_yet", 32'(halted), 32'd0);
      reqs = 0;
      if (mem_req) reqs++;
      tick(1);
      chk("mis_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (mem_req) reqs++;
         tick(1);
      end
      chk("mis_req_cycles", 32'(reqs), 32'd0);
      chk("mis_retired", retired_count, 32'd2);
      chk_reg("reg7", 5'd7, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
